// File: rtl/led_pkg.sv
// Shared types and defaults for the LED shift-register chain driver.
// Holds the frame FSM state type and the default frame geometry.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } led_state_e;

    localparam int LED_WIDTH = 16;
    localparam int LED_DIV   = 2;

endpackage

// File: rtl/led_serializer.sv
// Parallel-to-serial driver for the external LED shift-register chain.
// Shifts a captured word out MSB-first on a divided, registered serial clock.
module led_serializer
    import led_pkg::*;
#(
    parameter int WIDTH = LED_WIDTH,
    parameter int DIV   = LED_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] p_data,
    output logic             led_clk,
    output logic             led_sout,
    output logic             led_clrn,
    output logic             led_pen,
    output logic             busy,
    output logic             done
);

    localparam int DW = $clog2(DIV) + 1;
    localparam int BW = $clog2(WIDTH);

    localparam logic [DW-1:0] DIV_HALF = DW'(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(2 * DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    led_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             valid_q, valid_d;

    logic led_clk_q, led_clk_d;
    logic led_sout_q, led_sout_d;
    logic led_clrn_q;
    logic led_pen_q, led_pen_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Next-state logic; outputs are decoded from the current state and
    // registered, so every pin lags the FSM by exactly one cycle.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        valid_d    = valid_q;
        led_clk_d  = 1'b0;
        led_sout_d = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_q != IDLE);
        led_pen_d  = valid_q && (state_q != SHIFT);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = p_data;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                led_sout_d = shreg_q[WIDTH-1];
                // Low for the first half of the slot, high for the second:
                // the chain samples mid-slot with equal setup and hold.
                led_clk_d  = (div_cnt_q >= DIV_HALF);
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            valid_q    <= 1'b0;
            led_clk_q  <= 1'b0;
            led_sout_q <= 1'b0;
            led_clrn_q <= 1'b0;
            led_pen_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            valid_q    <= valid_d;
            led_clk_q  <= led_clk_d;
            led_sout_q <= led_sout_d;
            led_clrn_q <= 1'b1;
            led_pen_q  <= led_pen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign led_clk  = led_clk_q;
    assign led_sout = led_sout_q;
    assign led_clrn = led_clrn_q;
    assign led_pen  = led_pen_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_led_serializer.sv
// Bench for led_serializer: default geometry and an 8-bit, DIV=1 instance
// driven side by side and checked every cycle against a timeline model.
module tb_led_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [15:0] p_data;

    logic a_clk, a_sout, a_clrn, a_pen, a_busy, a_done;
    logic b_clk, b_sout, b_clrn, b_pen, b_busy, b_done;

    led_serializer #(.WIDTH(16), .DIV(2)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .p_data   (p_data),
        .led_clk  (a_clk),
        .led_sout (a_sout),
        .led_clrn (a_clrn),
        .led_pen  (a_pen),
        .busy     (a_busy),
        .done     (a_done)
    );

    led_serializer #(.WIDTH(8), .DIV(1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .p_data   (p_data[7:0]),
        .led_clk  (b_clk),
        .led_sout (b_sout),
        .led_clrn (b_clrn),
        .led_pen  (b_pen),
        .busy     (b_busy),
        .done     (b_done)
    );

    // Model: n = cycles since the accepted start edge of the current frame.
    int          wd [2] = '{16, 8};
    int          dv [2] = '{2, 1};
    bit          act [2] = '{1'b0, 1'b0};
    bit          vld [2] = '{1'b0, 1'b0};
    bit          clr [2] = '{1'b0, 1'b0};
    int          n [2] = '{0, 0};
    logic [15:0] dat [2] = '{16'h0, 16'h0};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cs = 0;

    int          rises_a, rises_b, dones_a, dones_b, done_cyc_a, done_cyc_b;
    logic [15:0] col_a;
    logic [7:0]  col_b;
    logic        prev_a = 1'b0;
    logic        prev_b = 1'b0;
    logic [15:0] d2;

    function automatic void model_edge(int k, bit r, bit s, logic [15:0] d);
        int last;
        last = 2 * dv[k] * wd[k] + 1;
        if (r) begin
            act[k] = 1'b0;
            vld[k] = 1'b0;
            clr[k] = 1'b0;
            n[k]   = 0;
            return;
        end
        clr[k] = 1'b1;
        if (act[k] && n[k] == last) vld[k] = 1'b1;
        if ((!act[k] || n[k] >= last) && s) begin
            act[k] = 1'b1;
            n[k]   = 0;
            dat[k] = d;
        end else if (act[k]) begin
            n[k]++;
        end
    endfunction

    // Expected {led_clk, led_sout, led_clrn, led_pen, busy, done}.
    function automatic logic [5:0] expect_o(int k);
        int   m, sl, fr;
        logic e_clk, e_sout, e_pen, e_busy, e_done;
        bit   inf;
        m  = n[k];
        sl = 2 * dv[k];
        fr = sl * wd[k];
        inf    = act[k] && m >= 1 && m <= fr;
        e_clk  = 1'b0;
        e_sout = 1'b0;
        if (inf) begin
            e_clk  = ((m - 1) % sl) >= dv[k];
            e_sout = dat[k][wd[k] - 1 - (m - 1) / sl];
        end
        e_busy = act[k] && m >= 1 && m <= fr + 1;
        e_done = act[k] && m == fr + 1;
        e_pen  = vld[k] && !inf;
        return {e_clk, e_sout, clr[k], e_pen, e_busy, e_done};
    endfunction

    task automatic check1(string tag, logic obs, logic exp);
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input logic [15:0] d);
        logic [5:0] ea, eb;
        rst    = r;
        start  = s;
        p_data = d;
        @(posedge clk);
        model_edge(0, r, s, d);
        model_edge(1, r, s, d);
        cyc++;
        @(negedge clk);
        ea = expect_o(0);
        eb = expect_o(1);
        vectors++;
        check1("a_led_clk",  a_clk,  ea[5]);
        check1("a_led_sout", a_sout, ea[4]);
        check1("a_led_clrn", a_clrn, ea[3]);
        check1("a_led_pen",  a_pen,  ea[2]);
        check1("a_busy",     a_busy, ea[1]);
        check1("a_done",     a_done, ea[0]);
        check1("b_led_clk",  b_clk,  eb[5]);
        check1("b_led_sout", b_sout, eb[4]);
        check1("b_led_clrn", b_clrn, eb[3]);
        check1("b_led_pen",  b_pen,  eb[2]);
        check1("b_busy",     b_busy, eb[1]);
        check1("b_done",     b_done, eb[0]);
        if (a_clk && !prev_a) begin
            rises_a++;
            col_a = {col_a[14:0], a_sout};
        end
        if (b_clk && !prev_b) begin
            rises_b++;
            col_b = {col_b[6:0], b_sout};
        end
        prev_a = a_clk;
        prev_b = b_clk;
        if (a_done) begin
            dones_a++;
            done_cyc_a = cyc;
        end
        if (b_done) begin
            dones_b++;
            done_cyc_b = cyc;
        end
    endtask

    task automatic clear_obs();
        rises_a = 0;
        rises_b = 0;
        dones_a = 0;
        dones_b = 0;
        done_cyc_a = -1;
        done_cyc_b = -1;
        col_a = '0;
        col_b = '0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        p_data = '0;
        clear_obs();

        // Reset held three cycles, then idle: clear releases, pen stays low.
        repeat (3) step(1'b1, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0);
        check1("clrn_after_release", a_clrn, 1'b1);
        repeat (5) step(1'b0, 1'b0, 16'($urandom));
        check1("pen_no_frame", a_pen, 1'b0);

        // Single frame A55A (B instance receives 5A).
        clear_obs();
        cs = cyc + 1;
        step(1'b0, 1'b1, 16'hA55A);
        repeat (69) step(1'b0, 1'b0, 16'($urandom));
        check_int("single_bits_a", int'(col_a), 32'hA55A);
        check_int("single_rises_a", rises_a, 16);
        check_int("single_done_at_a", done_cyc_a - cs, 65);
        check_int("single_dones_a", dones_a, 1);
        check1("single_pen_after", a_pen, 1'b1);
        check_int("single_bits_b", int'(col_b), 32'h5A);
        check_int("single_done_at_b", done_cyc_b - cs, 17);

        // Parameter sweep pattern: B instance gets C3.
        clear_obs();
        cs = cyc + 1;
        step(1'b0, 1'b1, 16'h3CC3);
        repeat (69) step(1'b0, 1'b0, 16'($urandom));
        check_int("sweep_bits_b", int'(col_b), 32'hC3);
        check_int("sweep_rises_b", rises_b, 8);
        check_int("sweep_done_at_b", done_cyc_b - cs, 17);
        check_int("sweep_bits_a", int'(col_a), 32'h3CC3);

        // Back-to-back with start held high: FFFF then 0000.
        clear_obs();
        cs = cyc + 1;
        step(1'b0, 1'b1, 16'hFFFF);
        repeat (131) step(1'b0, 1'b1, 16'h0000);
        check_int("b2b_rises_a", rises_a, 32);
        check_int("b2b_dones_a", dones_a, 2);
        check_int("b2b_second_done_a", done_cyc_a - cs, 131);
        check_int("b2b_second_bits_a", int'(col_a), 0);
        repeat (70) step(1'b0, 1'b0, 16'($urandom));

        // Start pulse mid-frame is ignored.
        clear_obs();
        step(1'b0, 1'b1, 16'h8001);
        repeat (19) step(1'b0, 1'b0, 16'($urandom));
        step(1'b0, 1'b1, 16'h1234);
        repeat (100) step(1'b0, 1'b0, 16'($urandom));
        check_int("ignored_bits_a", int'(col_a), 32'h8001);
        check_int("ignored_dones_a", dones_a, 1);
        check_int("ignored_rises_a", rises_a, 16);

        // Reset at cycle 30 of a frame, then a fresh frame.
        step(1'b0, 1'b1, 16'($urandom));
        repeat (29) step(1'b0, 1'b0, 16'($urandom));
        step(1'b1, 1'b0, 16'($urandom));
        check1("midrst_busy", a_busy, 1'b0);
        check1("midrst_pen", a_pen, 1'b0);
        check1("midrst_clk", a_clk, 1'b0);
        step(1'b0, 1'b0, 16'h0);
        clear_obs();
        d2 = 16'($urandom);
        step(1'b0, 1'b1, d2);
        repeat (69) step(1'b0, 1'b0, 16'($urandom));
        check_int("midrst_bits_a", int'(col_a), int'(d2));
        check_int("midrst_bits_b", int'(col_b), int'(d2[7:0]));
        check_int("midrst_rises_b", rises_b, 8);

        // Randomised traffic with occasional resets.
        repeat (1500) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0),
                 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
